sonar_scheduler: RTL and testbench
==================================

SONAR_SCHEDULER -- requirements
Module: sonar_scheduler

Interface
REQ-001 SHALL expose parameter TRIG_TICKS, default 1000, trigger pulse width in clocks (10 us).
REQ-002 SHALL expose parameter RISE_TIMEOUT, default 3000000, maximum clocks from trig fall to echo rise.
REQ-003 SHALL expose parameter ECHO_MAX, default 2500000, maximum echo width in clocks before timeout.
REQ-004 SHALL expose parameter GUARD_TICKS, default 1000000, idle clocks between pings (crosstalk decay).
REQ-005 SHALL expose parameter THRESHOLD, default 300000, echo width below which a sensor flags an obstacle.
REQ-006 SHALL have port CLK100MHZ  in  1  sole clock, all logic on rising edge.
REQ-007 SHALL have port CPU_RESETN  in  1  reset, synchronous, active-low.
REQ-008 SHALL have port sensor_en  in  4  per-sensor enable mask.
REQ-009 SHALL have port echo  in  4  raw echo inputs, asynchronous.
REQ-010 SHALL have port trig  out  4  trigger outputs, at most one high at a time.
REQ-011 SHALL have port meas_valid  out  1  result available.
REQ-012 SHALL have port meas_ready  in  1  consumer accepts result.
REQ-013 SHALL have port meas_id  out  2  sensor index of result.
REQ-014 SHALL have port meas_count  out  24  echo width in clocks.
REQ-015 SHALL have port meas_timeout  out  1  result is a timeout (no rise, or width reached ECHO_MAX).
REQ-016 SHALL have port obstacle  out  4  registered per-sensor obstacle flags.

Function
REQ-017 SHALL pass each echo bit through a 2-flop synchronizer before use; all echo timing refers to the synchronized signal.
REQ-018 SHALL implement states IDLE, TRIG, WAIT_RISE, MEASURE, REPORT, GUARD with one shared 24-bit tick counter.
REQ-019 IDLE: SHALL select the next enabled sensor after the last serviced index (round-robin, wrap 3->0) and enter TRIG; if sensor_en==0, SHALL remain in IDLE.
REQ-020 TRIG: SHALL drive trig[id] high for exactly TRIG_TICKS cycles, then go to WAIT_RISE with counter cleared.
REQ-021 WAIT_RISE: on echo[id] high SHALL go to MEASURE with count=1; if the counter reaches RISE_TIMEOUT first, SHALL go to REPORT with meas_timeout=1, meas_count=0.
REQ-022 MEASURE: SHALL increment count each cycle echo[id] is high; on echo low SHALL go to REPORT with meas_timeout=0; on count reaching ECHO_MAX SHALL go to REPORT with meas_timeout=1, meas_count=ECHO_MAX.
REQ-023 REPORT: SHALL assert meas_valid with id/count/timeout held stable until the cycle meas_valid&&meas_ready, then go to GUARD; the scheduler stalls indefinitely while meas_ready is low.
REQ-024 SHALL update obstacle[id] in the accepting cycle: 1 if !timeout && count<THRESHOLD, else 0; count==THRESHOLD yields 0.
REQ-025 GUARD: SHALL wait GUARD_TICKS cycles, then return to IDLE.
REQ-026 Clearing sensor_en[id] mid-ping SHALL NOT abort the ping; the disabled sensor's obstacle bit SHALL be cleared when it is next skipped in IDLE.
REQ-027 SHALL never assert two trig bits simultaneously, and SHALL keep trig low outside TRIG.

Reset
REQ-028 While CPU_RESETN is low at a clock edge: state=IDLE, trig=0, meas_valid=0, meas_id=0, meas_count=0, meas_timeout=0, obstacle=0, synchronizers=0, last-serviced index=3 (so sensor 0 is served first).
REQ-029 Reset asserted mid-ping SHALL drop trig and meas_valid on that edge; no partial result is reported.

Configuration
REQ-030 With SONAR_FILTER_EN defined, obstacle[id] SHALL set only after two consecutive accepted below-threshold results for that sensor and clear on any single non-obstacle result; a per-sensor 1-bit history register is added, cleared by reset.
REQ-031 Without SONAR_FILTER_EN, obstacle[id] SHALL follow each accepted result directly per REQ-024.

Verification
REQ-032 sensor_en=0001, echo[0] high 200000 clocks after trig falls, ready=1 -> trig[0] high 1000 cycles; result id=0, count=200000, timeout=0; obstacle=0001.
REQ-033 sensor_en=1010, all echoes 400000 wide -> trig order 1,3,1,3; guard of 1000000 cycles between pings; obstacle=0000.
REQ-034 sensor_en=0100, echo never rises -> after 3000000 cycles result id=2, count=0, timeout=1; obstacle[2]=0.
REQ-035 meas_ready held low 5000 cycles in REPORT -> meas_valid and fields stable throughout; no new trig until accept plus GUARD_TICKS.
REQ-036 CPU_RESETN pulsed low during MEASURE -> next edge trig=0, meas_valid=0, obstacle=0; next ping targets sensor 0.
REQ-037 SONAR_FILTER_EN defined, sensor 0 widths 100000 then 100000 -> obstacle[0] stays 0 after the first accept, becomes 1 after the second.

Source files
------------

// File: rtl/sonar_scheduler.sv
// sonar_scheduler: round-robin trigger/echo timer for four ultrasonic rangers with registered obstacle flags.
// Optional SONAR_FILTER_EN: obstacle sets only after two consecutive below-threshold results per sensor.
module sonar_scheduler #(
    parameter int TRIG_TICKS   = 1000,
    parameter int RISE_TIMEOUT = 3000000,
    parameter int ECHO_MAX     = 2500000,
    parameter int GUARD_TICKS  = 1000000,
    parameter int THRESHOLD    = 300000
) (
    input  logic        CLK100MHZ,
    input  logic        CPU_RESETN,
    input  logic [3:0]  sensor_en,
    input  logic [3:0]  echo,
    output logic [3:0]  trig,
    output logic        meas_valid,
    input  logic        meas_ready,
    output logic [1:0]  meas_id,
    output logic [23:0] meas_count,
    output logic        meas_timeout,
    output logic [3:0]  obstacle
);
    typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, REPORT, GUARD} state_t;
    state_t      state_q, state_d;
    logic [3:0]  sync1_q, sync2_q;
    logic [1:0]  id_q, id_d, mid_q, mid_d, cand;
    logic [23:0] cnt_q, cnt_d, count_q, count_d;
    logic        timeout_q, timeout_d, hit, found, echo_s;
    logic [3:0]  obst_q, obst_d;
`ifdef SONAR_FILTER_EN
    logic [3:0]  hist_q, hist_d;
`endif
    assign trig         = (state_q == TRIG) ? 4'b1 << id_q : 4'b0;
    assign meas_valid   = state_q == REPORT;
    assign meas_id      = mid_q;
    assign meas_count   = count_q;
    assign meas_timeout = timeout_q;
    assign obstacle     = obst_q;
    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        mid_d     = mid_q;
        cnt_d     = cnt_q;
        count_d   = count_q;
        timeout_d = timeout_q;
        obst_d    = obst_q;
`ifdef SONAR_FILTER_EN
        hist_d    = hist_q;
`endif
        found     = 1'b0;
        cand      = 2'd0;
        echo_s    = sync2_q[id_q];
        hit       = !timeout_q && count_q < 24'(THRESHOLD);
        case (state_q)
            IDLE: begin
                // scan after last index; disabled sensors passed over lose their flag
                for (int k = 1; k <= 4; k++) begin
                    cand = id_q + 2'(k);
                    if (!found) begin
                        if (sensor_en[cand]) begin
                            found = 1'b1;
                            id_d  = cand;
                        end else begin
                            obst_d[cand] = 1'b0;
`ifdef SONAR_FILTER_EN
                            hist_d[cand] = 1'b0;
`endif
                        end
                    end
                end
                if (found) begin
                    state_d = TRIG;
                    cnt_d   = 24'd0;
                end
            end
            TRIG: begin
                state_d = (cnt_q == 24'(TRIG_TICKS - 1)) ? WAIT_RISE : TRIG;
                cnt_d   = (cnt_q == 24'(TRIG_TICKS - 1)) ? 24'd0 : cnt_q + 24'd1;
            end
            WAIT_RISE: begin
                if (echo_s) begin
                    state_d = MEASURE;
                    cnt_d   = 24'd1;
                end else if (cnt_q == 24'(RISE_TIMEOUT - 1)) begin
                    state_d   = REPORT;
                    mid_d     = id_q;
                    count_d   = 24'd0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            MEASURE: begin
                if (!echo_s) begin
                    state_d   = REPORT;
                    mid_d     = id_q;
                    count_d   = cnt_q;
                    timeout_d = 1'b0;
                end else if (cnt_q + 24'd1 == 24'(ECHO_MAX)) begin
                    state_d   = REPORT;
                    mid_d     = id_q;
                    count_d   = 24'(ECHO_MAX);
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            REPORT: begin
                if (meas_ready) begin
                    state_d = GUARD;
                    cnt_d   = 24'd0;
`ifdef SONAR_FILTER_EN
                    obst_d[mid_q] = hit && hist_q[mid_q];
                    hist_d[mid_q] = hit;
`else
                    obst_d[mid_q] = hit;
`endif
                end
            end
            GUARD: begin
                state_d = (cnt_q == 24'(GUARD_TICKS - 1)) ? IDLE : GUARD;
                cnt_d   = cnt_q + 24'd1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            state_q   <= IDLE;
            sync1_q   <= 4'd0;
            sync2_q   <= 4'd0;
            id_q      <= 2'd3;
            mid_q     <= 2'd0;
            cnt_q     <= 24'd0;
            count_q   <= 24'd0;
            timeout_q <= 1'b0;
            obst_q    <= 4'd0;
`ifdef SONAR_FILTER_EN
            hist_q    <= 4'd0;
`endif
        end else begin
            state_q   <= state_d;
            sync1_q   <= echo;
            sync2_q   <= sync1_q;
            id_q      <= id_d;
            mid_q     <= mid_d;
            cnt_q     <= cnt_d;
            count_q   <= count_d;
            timeout_q <= timeout_d;
            obst_q    <= obst_d;
`ifdef SONAR_FILTER_EN
            hist_q    <= hist_d;
`endif
        end
    end
endmodule

// File: tb/tb_sonar_scheduler.sv
// tb_sonar_scheduler: directed and randomized pings against a round-robin/threshold reference model.
module tb_sonar_scheduler;
    localparam int TT = 10, RT = 400, EM = 250, GT = 100, TH = 60;
    logic        clk = 1'b0, rstn = 1'b0, ready = 1'b0;
    logic [3:0]  en = 4'd0, echo = 4'd0;
    logic [3:0]  trig, obstacle;
    logic        meas_valid, meas_timeout;
    logic [1:0]  meas_id;
    logic [23:0] meas_count;
    int          errors = 0, checks = 0, last = 3;
    logic [3:0]  obs_m = 4'd0, hist_m = 4'd0;

    sonar_scheduler #(.TRIG_TICKS(TT), .RISE_TIMEOUT(RT), .ECHO_MAX(EM), .GUARD_TICKS(GT), .THRESHOLD(TH)) dut (
        .CLK100MHZ(clk), .CPU_RESETN(rstn), .sensor_en(en), .echo(echo), .trig(trig),
        .meas_valid(meas_valid), .meas_ready(ready), .meas_id(meas_id), .meas_count(meas_count),
        .meas_timeout(meas_timeout), .obstacle(obstacle));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    // next enabled sensor after the last one; disabled sensors passed over lose their flag
    task automatic pick(output int s);
        s = -1;
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (last + k) % 4;
            if (s < 0) begin
                if (en[c]) s = c;
                else begin
                    obs_m[c]  = 1'b0;
                    hist_m[c] = 1'b0;
                end
            end
        end
    endtask

    task automatic ping(input int rise, input int width, input int hold, input logic [3:0] mid_en);
        int s, w, exp_cnt;
        logic exp_to, hit, stable;
        logic [1:0] i0;
        logic [23:0] c0;
        logic t0;
        pick(s);
        w = 0;
        while (trig == 4'd0 && w < 50) begin w++; step(); end
        chk("trig_sel", trig, 4'b1 << s);
        if (s < 0 || trig == 4'd0) return;
        w = 0;
        while (trig != 4'd0 && w < TT + 20) begin w++; step(); end
        chk("trig_width", w, TT);
        last = s;
        en = mid_en;
        exp_to  = width == 0 || width >= EM;
        exp_cnt = width == 0 ? 0 : (width >= EM ? EM : width);
        step(rise);
        if (width > 0) begin
            echo[s] = 1'b1;
            step(width);
            echo[s] = 1'b0;
        end
        w = 0;
        while (!meas_valid && w < RT + 20) begin w++; step(); end
        if (width == 0) chk("rise_timeout_latency", rise + w, RT);
        chk("valid", meas_valid, 1);
        chk("id", meas_id, s);
        chk("count", meas_count, exp_cnt);
        chk("timeout", meas_timeout, exp_to);
        i0 = meas_id; c0 = meas_count; t0 = meas_timeout; stable = 1'b1;
        repeat (hold) begin
            step();
            if (!meas_valid || meas_id !== i0 || meas_count !== c0 || meas_timeout !== t0 || trig != 4'd0) stable = 1'b0;
        end
        chk("stall_stable", stable, 1);
        ready = 1'b1;
        step();
        ready = 1'b0;
        hit = !exp_to && exp_cnt < TH;
`ifdef SONAR_FILTER_EN
        obs_m[s]  = hit && hist_m[s];
        hist_m[s] = hit;
`else
        obs_m[s] = hit;
`endif
        chk("accept_drop", meas_valid, 0);
        chk("obstacle", obstacle, obs_m);
        stable = 1'b1;
        for (int i = 0; i < GT; i++) begin
            if (trig != 4'd0) stable = 1'b0;
            step();
        end
        chk("guard_quiet", stable, 1);
    endtask

    initial begin
        int s, w;
        step(3);
        chk("rst_trig", trig, 0);
        chk("rst_valid", meas_valid, 0);
        chk("rst_id", meas_id, 0);
        chk("rst_count", meas_count, 0);
        chk("rst_timeout", meas_timeout, 0);
        chk("rst_obstacle", obstacle, 0);
        rstn = 1'b1;
        en = 4'b0001;
        ping(20, 40, 0, 4'b0001);
        en = 4'b1010;
        repeat (4) ping(10, 80, 0, 4'b1010);
        en = 4'b0100;
        ping(0, 0, 0, 4'b0100);
        en = 4'b0001;
        ping(5, 30, 50, 4'b0001);
        ping(3, TH, 0, 4'b0001);
        ping(3, TH - 1, 2, 4'b0001);
        ping(3, TH - 1, 0, 4'b0001);
        ping(3, EM - 1, 0, 4'b0001);
        ping(3, EM, 0, 4'b0001);
        ping(3, EM + 15, 1, 4'b0001);
        ping(3, 20, 0, 4'b0001);
        ping(3, 20, 0, 4'b0001);
        en = 4'b0011;
        ping(4, 25, 0, 4'b0010);
        ping(4, 25, 0, 4'b0010);
        en = 4'b0000;
        pick(s);
        step(60);
        chk("idle_no_trig", trig, 0);
        chk("idle_obstacle", obstacle, obs_m);
        en = 4'b0001;
        ping(3, 20, 0, 4'b0001);
        ping(3, 20, 0, 4'b0001);
        pick(s);
        w = 0;
        while (trig == 4'd0 && w < 50) begin w++; step(); end
        w = 0;
        while (trig != 4'd0 && w < TT + 20) begin w++; step(); end
        step(3);
        echo[0] = 1'b1;
        step(20);
        rstn = 1'b0;
        step();
        chk("midrst_trig", trig, 0);
        chk("midrst_valid", meas_valid, 0);
        chk("midrst_obstacle", obstacle, 0);
        echo = 4'd0;
        rstn = 1'b1;
        last = 3; obs_m = 4'd0; hist_m = 4'd0;
        en = 4'b1111;
        ping(5, 30, 0, 4'b1111);
        repeat (15) begin
            int r;
            en = 4'($urandom_range(1, 15));
            r = $urandom_range(0, 9);
            ping($urandom_range(0, 40), r == 0 ? 0 : $urandom_range(1, EM + 10), $urandom_range(0, 4),
                 4'($urandom_range(1, 15)));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
